// File: rtl/dma_xfer_engine.sv
// dma_xfer_engine: single-channel DMA sequencer moving 32-bit words via one read and one write per word.
// Optional abort input is compiled in when DMA_XFER_ABORT_EN is defined.
module dma_xfer_engine #(
  parameter int WIDTH_p   = 32,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_start,
  input  logic               cfg_dir,
  input  logic               cfg_io_inc,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [WIDTH_p-1:0] cfg_io_addr,
  input  logic [WIDTH_p-1:0] cfg_mem_addr,
  input  logic               irq_clr,
`ifdef DMA_XFER_ABORT_EN
  input  logic               abort,
`endif
  output logic               m_req,
  output logic               m_we,
  output logic [WIDTH_p-1:0] m_addr,
  output logic [WIDTH_p-1:0] m_wdata,
  input  logic               m_gnt,
  input  logic               m_rvalid,
  input  logic [WIDTH_p-1:0] m_rdata,
  output logic               busy,
  output logic [LEN_W-1:0]   remaining,
  output logic               done_irq
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  localparam logic [WIDTH_p-1:0] STEP = WIDTH_p'(ADDR_STEP);

  state_t             state;
  logic [WIDTH_p-1:0] io_addr;
  logic [WIDTH_p-1:0] mem_addr;
  logic               dir_q;
  logic               io_inc_q;
  logic [WIDTH_p-1:0] src_addr;
  logic [WIDTH_p-1:0] dst_addr;

  assign src_addr = dir_q ? mem_addr : io_addr;
  assign dst_addr = dir_q ? io_addr  : mem_addr;

`ifdef DMA_XFER_ABORT_EN
  logic busy_state;
  assign busy_state = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
`endif

  // m_wdata doubles as the word buffer between the read and the write phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      remaining <= '0;
      done_irq  <= 1'b0;
      io_addr   <= '0;
      mem_addr  <= '0;
      dir_q     <= 1'b0;
      io_inc_q  <= 1'b0;
    end else begin
      if (irq_clr) done_irq <= 1'b0;
`ifdef DMA_XFER_ABORT_EN
      if (abort && busy_state) begin
        state <= IDLE;
        busy  <= 1'b0;
        m_req <= 1'b0;
        if (state == WR_REQ && m_req && m_gnt) remaining <= remaining - LEN_W'(1);
      end else
`endif
      begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              io_addr   <= cfg_io_addr;
              mem_addr  <= cfg_mem_addr;
              dir_q     <= cfg_dir;
              io_inc_q  <= cfg_io_inc;
              remaining <= cfg_len;
              busy      <= 1'b1;
              state     <= (cfg_len == '0) ? DONE : RD_REQ;
            end
          end
          // Request is raised one cycle after entry, which yields the 4-cycle word minimum
          RD_REQ: begin
            if (m_req && m_gnt) begin
              m_req <= 1'b0;
              state <= RD_WAIT;
            end else begin
              m_req  <= 1'b1;
              m_we   <= 1'b0;
              m_addr <= src_addr;
            end
          end
          RD_WAIT: begin
            if (m_rvalid) begin
              m_wdata <= m_rdata;
              m_req   <= 1'b1;
              m_we    <= 1'b1;
              m_addr  <= dst_addr;
              state   <= WR_REQ;
            end
          end
          WR_REQ: begin
            if (m_req && m_gnt) begin
              m_req     <= 1'b0;
              m_we      <= 1'b0;
              remaining <= remaining - LEN_W'(1);
              mem_addr  <= mem_addr + STEP;
              if (io_inc_q) io_addr <= io_addr + STEP;
              state     <= (remaining == LEN_W'(1)) ? DONE : RD_REQ;
            end
          end
          DONE: begin
            busy     <= 1'b0;
            done_irq <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Scoreboard bench for dma_xfer_engine: directed transfers, expected bus transactions queued up front.
// Bus model grants after a programmable stall and returns rdata = addr ^ 0xDEAD0000 one cycle after a read grant.
module tb_dma_xfer_engine;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_dir = 1'b0;
  logic        cfg_io_inc = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_io_addr = '0;
  logic [31:0] cfg_mem_addr = '0;
  logic        irq_clr = 1'b0;
`ifdef DMA_XFER_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        busy;
  logic [15:0] remaining;
  logic        done_irq;

  int   checks = 0;
  int   errors = 0;
  int   stall_cfg = 0;
  int   stall_cnt = 0;
  logic rd_pend = 1'b0;
  logic [31:0] rd_addr = '0;
  txn_t q[$];

  dma_xfer_engine dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_dir(cfg_dir),
    .cfg_io_inc(cfg_io_inc), .cfg_len(cfg_len), .cfg_io_addr(cfg_io_addr),
    .cfg_mem_addr(cfg_mem_addr), .irq_clr(irq_clr),
`ifdef DMA_XFER_ABORT_EN
    .abort(abort),
`endif
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .remaining(remaining), .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    q.push_back(t);
  endtask

  // Bus slave: decisions made on the falling edge so the DUT sees them at the next rising edge
  always @(negedge clk) begin
    m_rvalid = 1'b0;
    if (rd_pend) begin
      m_rvalid = 1'b1;
      m_rdata  = rd_addr ^ 32'hDEAD_0000;
      rd_pend  = 1'b0;
    end
    m_gnt = 1'b0;
    if (m_req && reset) begin
      if (stall_cnt < stall_cfg) stall_cnt++;
      else begin
        m_gnt = 1'b1;
        stall_cnt = 0;
        if (!m_we) begin
          rd_pend = 1'b1;
          rd_addr = m_addr;
        end
      end
    end
  end

  // Monitor: every cycle a request is up it must match the queue head; pop on grant
  always @(negedge clk) begin
    #2;
    if (m_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: got addr=%h we=%b, expected no request at %0t", m_addr, m_we, $time);
      end else begin
        chk("req_we", {31'b0, m_we}, {31'b0, q[0].we});
        chk("req_addr", m_addr, q[0].addr);
        if (q[0].we) chk("req_wdata", m_wdata, q[0].data);
        if (m_gnt) void'(q.pop_front());
      end
    end
  end

  task automatic start_pulse(input logic dir, input logic inc, input logic [15:0] len,
                             input logic [31:0] io, input logic [31:0] mem);
    @(negedge clk);
    cfg_dir = dir; cfg_io_inc = inc; cfg_len = len;
    cfg_io_addr = io; cfg_mem_addr = mem; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic run_xfer(input logic dir, input logic inc, input logic [15:0] len,
                          input logic [31:0] io, input logic [31:0] mem,
                          input bit clr_in_done, input bit restart, output int cyc);
    start_pulse(dir, inc, len, io, mem);
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      irq_clr = clr_in_done && (remaining == 16'd0);
      if (restart && cyc == 6) begin
        cfg_start = 1'b1; cfg_len = 16'd7; cfg_dir = ~dir;
        cfg_io_addr = 32'h7777_0000; cfg_mem_addr = 32'h8888_0000;
      end else cfg_start = 1'b0;
      @(negedge clk);
    end
    cfg_start = 1'b0;
    irq_clr = 1'b0;
    chk("xfer_timeout", {31'b0, cyc >= 2000}, 32'd0);
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_cleared", {31'b0, done_irq}, 32'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_m_we", {31'b0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_remaining", {16'b0, remaining}, 32'd0);
    chk("rst_done_irq", {31'b0, done_irq}, 32'd0);
    reset = 1'b1;

    // IO->memory, incrementing IO side
    push(0, 32'h1000, 32'hDEAD1000); push(1, 32'h2000, 32'hDEAD1000);
    push(0, 32'h1004, 32'hDEAD1004); push(1, 32'h2004, 32'hDEAD1004);
    push(0, 32'h1008, 32'hDEAD1008); push(1, 32'h2008, 32'hDEAD1008);
    push(0, 32'h100C, 32'hDEAD100C); push(1, 32'h200C, 32'hDEAD100C);
    run_xfer(0, 1, 16'd4, 32'h1000, 32'h2000, 0, 0, cyc);
    chk("t1_busy_cycles", cyc, 32'd17);
    chk("t1_remaining", {16'b0, remaining}, 32'd0);
    chk("t1_done_irq", {31'b0, done_irq}, 32'd1);
    chk("t1_all_txn", q.size(), 32'd0);
    clear_irq();

    // memory->IO, fixed IO address
    push(0, 32'h3000, 32'hDEAD3000); push(1, 32'h0400, 32'hDEAD3000);
    push(0, 32'h3004, 32'hDEAD3004); push(1, 32'h0400, 32'hDEAD3004);
    push(0, 32'h3008, 32'hDEAD3008); push(1, 32'h0400, 32'hDEAD3008);
    run_xfer(1, 0, 16'd3, 32'h0400, 32'h3000, 0, 0, cyc);
    chk("t2_busy_cycles", cyc, 32'd13);
    chk("t2_done_irq", {31'b0, done_irq}, 32'd1);
    chk("t2_all_txn", q.size(), 32'd0);
    clear_irq();

    // zero-length transfer: no bus traffic
    run_xfer(0, 1, 16'd0, 32'h1234, 32'h5678, 0, 0, cyc);
    chk("t3_busy_cycles", cyc, 32'd1);
    chk("t3_done_irq", {31'b0, done_irq}, 32'd1);
    chk("t3_remaining", {16'b0, remaining}, 32'd0);
    clear_irq();

    // 5-cycle grant stall, ignored restart, irq_clr coinciding with set
    stall_cfg = 5;
    push(0, 32'h0800, 32'hDEAD0800); push(1, 32'h0900, 32'hDEAD0800);
    push(0, 32'h0804, 32'hDEAD0804); push(1, 32'h0904, 32'hDEAD0804);
    run_xfer(0, 1, 16'd2, 32'h0800, 32'h0900, 1, 1, cyc);
    chk("t4_busy_cycles", cyc, 32'd29);
    chk("t4_set_wins", {31'b0, done_irq}, 32'd1);
    chk("t4_remaining", {16'b0, remaining}, 32'd0);
    chk("t4_all_txn", q.size(), 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_restart", {31'b0, busy}, 32'd0);
    stall_cfg = 0;
    clear_irq();

    // memory address wrap
    push(0, 32'h0500, 32'hDEAD0500); push(1, 32'hFFFF_FFFC, 32'hDEAD0500);
    push(0, 32'h0504, 32'hDEAD0504); push(1, 32'h0000_0000, 32'hDEAD0504);
    run_xfer(0, 1, 16'd2, 32'h0500, 32'hFFFF_FFFC, 0, 0, cyc);
    chk("t5_busy_cycles", cyc, 32'd9);
    chk("t5_all_txn", q.size(), 32'd0);
    clear_irq();

    // asynchronous reset during RD_WAIT of word 2 of 4
    push(0, 32'h0A00, 32'hDEAD0A00); push(1, 32'h0B00, 32'hDEAD0A00);
    push(0, 32'h0A04, 32'hDEAD0A04);
    start_pulse(0, 1, 16'd4, 32'h0A00, 32'h0B00);
    cyc = 0;
    while (q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6_reach_word2", {31'b0, cyc >= 500}, 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_m_req", {31'b0, m_req}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_remaining", {16'b0, remaining}, 32'd0);
    chk("t6_done_irq", {31'b0, done_irq}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

`ifdef DMA_XFER_ABORT_EN
    // abort during RD_WAIT of word 2 of 4
    push(0, 32'h0C00, 32'hDEAD0C00); push(1, 32'h0D00, 32'hDEAD0C00);
    push(0, 32'h0C04, 32'hDEAD0C04);
    start_pulse(0, 1, 16'd4, 32'h0C00, 32'h0D00);
    cyc = 0;
    while (q.size() != 0 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_remaining", {16'b0, remaining}, 32'd3);
    chk("t7_busy", {31'b0, busy}, 32'd0);
    chk("t7_m_req", {31'b0, m_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t7_done_irq", {31'b0, done_irq}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
